// File: rtl/nback_engine.sv
// nback_engine: runtime-configurable N-back game engine.
//   Each round the engine fetches a random symbol over a valid/ready
//   handshake. It shows the symbol for SYMBOL_TICKS cycles, then shows a
//   blank pause for PAUSE_TICKS cycles. It then judges the player's
//   "match" answer against the symbol seen n rounds earlier.
//   The game ends after ROUNDS rounds (win), or earlier once MAX_ERRORS
//   wrong judgements have been made (loss).
// Ports:
//   clk_i, s_rst_n_i       clock and synchronous active-low reset
//   start_i, n_sel_i       start pulse and requested depth (latched at start)
//   answer_stb_i           player "match" strobe
//   symbol_i/_valid_i      random symbol source; symbol_ready_o in FETCH
//   current_symbol_o       shown symbol (0 outside SHOW); symbol_on_o in SHOW
//   in_game_o              high while a game is running
//   round_o/score_o/errors_o  live counters
//   round_done_stb_o       one-cycle pulse per judged round
//   round_correct_o        judgement result, qualified by round_done_stb_o
//   result_valid_o         game result is valid
//   win_nlost_o            game result (1 = won, 0 = lost)
module nback_engine #(
  parameter int N_MAX        = 4,
  parameter int SYMBOL_W     = 8,
  parameter int SYMBOL_TICKS = 200000000,
  parameter int PAUSE_TICKS  = 200000000,
  parameter int ROUNDS       = 32,
  parameter int MAX_ERRORS   = 3,
  parameter int SCORE_W      = 8
) (
  input  logic                       clk_i,
  input  logic                       s_rst_n_i,
  input  logic                       start_i,
  input  logic [$clog2(N_MAX+1)-1:0] n_sel_i,
  input  logic                       answer_stb_i,
  input  logic [SYMBOL_W-1:0]        symbol_i,
  input  logic                       symbol_valid_i,
  output logic                       symbol_ready_o,
  output logic [SYMBOL_W-1:0]        current_symbol_o,
  output logic                       symbol_on_o,
  output logic                       in_game_o,
  output logic [SCORE_W-1:0]         round_o,
  output logic [SCORE_W-1:0]         score_o,
  output logic [SCORE_W-1:0]         errors_o,
  output logic                       round_done_stb_o,
  output logic                       round_correct_o,
  output logic                       result_valid_o,
  output logic                       win_nlost_o
);

  localparam int NW   = $clog2(N_MAX+1);
  localparam int IW   = (N_MAX > 1) ? $clog2(N_MAX) : 1;
  localparam int TMAX = (SYMBOL_TICKS > PAUSE_TICKS) ? SYMBOL_TICKS : PAUSE_TICKS;
  localparam int TW   = $clog2(TMAX+1);

  typedef enum logic [2:0] {IDLE, FETCH, SHOW, PAUSE, JUDGE, DONE} state_e;

  state_e                           state_q, state_d;
  logic [TW-1:0]                    tick_q, tick_d;
  logic [NW-1:0]                    n_q, n_d;
  logic [SYMBOL_W-1:0]              sym_q, sym_d;
  logic [N_MAX-1:0][SYMBOL_W-1:0]   hist_q, hist_d;
  logic                             answered_q, answered_d;
  logic [SCORE_W-1:0]               round_q, round_d;
  logic [SCORE_W-1:0]               score_q, score_d;
  logic [SCORE_W-1:0]               errors_q, errors_d;
  logic                             win_q, win_d;

  logic          match, correct;
  logic [IW-1:0] hidx;

  // hist_q[0] holds the previous round's symbol, so depth n compares with entry n-1.
  assign hidx    = IW'(n_q - 1'b1);
  assign match   = (round_q >= SCORE_W'(n_q)) && (sym_q == hist_q[hidx]);
  assign correct = (answered_q == match);

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    n_d        = n_q;
    sym_d      = sym_q;
    hist_d     = hist_q;
    answered_d = answered_q;
    round_d    = round_q;
    score_d    = score_q;
    errors_d   = errors_q;
    win_d      = win_q;

    // Strobes only count while the symbol or the pause is on screen.
    if ((state_q == SHOW || state_q == PAUSE) && answer_stb_i) answered_d = 1'b1;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          if (n_sel_i == '0)               n_d = NW'(1);
          else if (n_sel_i > NW'(N_MAX))   n_d = NW'(N_MAX);
          else                             n_d = n_sel_i;
          round_d    = '0;
          score_d    = '0;
          errors_d   = '0;
          hist_d     = '0;
          answered_d = 1'b0;
          win_d      = 1'b0;
          tick_d     = '0;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        if (symbol_valid_i) begin
          sym_d   = symbol_i;
          tick_d  = '0;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (tick_q == TW'(SYMBOL_TICKS-1)) begin
          tick_d  = '0;
          state_d = PAUSE;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      PAUSE: begin
        if (tick_q == TW'(PAUSE_TICKS-1)) begin
          tick_d  = '0;
          state_d = JUDGE;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      JUDGE: begin
        if (correct) score_d  = (score_q == {SCORE_W{1'b1}}) ? score_q : score_q + 1'b1;
        else         errors_d = errors_q + 1'b1;
        for (int i = N_MAX-1; i > 0; i--) hist_d[i] = hist_q[i-1];
        hist_d[0]  = sym_q;
        answered_d = 1'b0;
        round_d    = round_q + 1'b1;
        tick_d     = '0;
        // The loss check takes priority over completing the final round.
        if (errors_d == SCORE_W'(MAX_ERRORS)) begin
          win_d   = 1'b0;
          state_d = DONE;
        end else if (round_q == SCORE_W'(ROUNDS-1)) begin
          win_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!s_rst_n_i) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      n_q        <= NW'(1);
      sym_q      <= '0;
      hist_q     <= '0;
      answered_q <= 1'b0;
      round_q    <= '0;
      score_q    <= '0;
      errors_q   <= '0;
      win_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      n_q        <= n_d;
      sym_q      <= sym_d;
      hist_q     <= hist_d;
      answered_q <= answered_d;
      round_q    <= round_d;
      score_q    <= score_d;
      errors_q   <= errors_d;
      win_q      <= win_d;
    end
  end

  // All outputs decode directly from flops.
  assign symbol_ready_o   = (state_q == FETCH);
  assign symbol_on_o      = (state_q == SHOW);
  assign current_symbol_o = (state_q == SHOW) ? sym_q : '0;
  assign in_game_o        = (state_q == FETCH) || (state_q == SHOW) ||
                            (state_q == PAUSE) || (state_q == JUDGE);
  assign round_o          = round_q;
  assign score_o          = score_q;
  assign errors_o         = errors_q;
  assign round_done_stb_o = (state_q == JUDGE);
  assign round_correct_o  = (state_q == JUDGE) && correct;
  assign result_valid_o   = (state_q == DONE);
  assign win_nlost_o      = win_q;

endmodule

// File: tb/tb_nback_engine.sv
// Testbench for nback_engine. It plays directed and random games against a
// game-level reference model. The model keeps the list of shown symbols,
// indexed by round, and applies the scoring rules directly.
module tb_nback_engine;
  localparam int N_MAX = 4, SW = 8, ST = 4, PT = 2, RND = 6, ME = 2, SCW = 8;
  localparam int NW = $clog2(N_MAX+1);

  logic            clk_i = 1'b0;
  logic            s_rst_n_i, start_i, answer_stb_i, symbol_valid_i;
  logic [NW-1:0]   n_sel_i;
  logic [SW-1:0]   symbol_i;
  logic            symbol_ready_o, symbol_on_o, in_game_o;
  logic [SW-1:0]   current_symbol_o;
  logic [SCW-1:0]  round_o, score_o, errors_o;
  logic            round_done_stb_o, round_correct_o, result_valid_o, win_nlost_o;

  always #5 clk_i = ~clk_i;

  nback_engine #(.N_MAX(N_MAX), .SYMBOL_W(SW), .SYMBOL_TICKS(ST), .PAUSE_TICKS(PT),
                 .ROUNDS(RND), .MAX_ERRORS(ME), .SCORE_W(SCW)) dut (
    .clk_i(clk_i), .s_rst_n_i(s_rst_n_i), .start_i(start_i), .n_sel_i(n_sel_i),
    .answer_stb_i(answer_stb_i), .symbol_i(symbol_i), .symbol_valid_i(symbol_valid_i),
    .symbol_ready_o(symbol_ready_o), .current_symbol_o(current_symbol_o),
    .symbol_on_o(symbol_on_o), .in_game_o(in_game_o), .round_o(round_o),
    .score_o(score_o), .errors_o(errors_o), .round_done_stb_o(round_done_stb_o),
    .round_correct_o(round_correct_o), .result_valid_o(result_valid_o),
    .win_nlost_o(win_nlost_o));

  int n_assert = 0, n_fail = 0;

  // reference model state
  int         m_n, m_round, m_score, m_err;
  bit         m_done, m_win;
  logic [7:0] m_syms[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_i); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {symbol_ready_o, current_symbol_o, symbol_on_o, in_game_o, round_o, score_o,
              errors_o, round_done_stb_o, round_correct_o, result_valid_o, win_nlost_o}, 64'd0);
  endtask

  task automatic start_game(input int nsel);
    n_sel_i = NW'(nsel);
    start_i = 1'b1;
    step;
    start_i = 1'b0;
    n_sel_i = NW'($urandom);   // mid-game changes must have no effect
    m_n     = (nsel == 0) ? 1 : (nsel > N_MAX) ? N_MAX : nsel;
    m_round = 0; m_score = 0; m_err = 0; m_done = 0; m_win = 0;
    m_syms.delete();
    chk("start_state", {symbol_ready_o, in_game_o, result_valid_o, symbol_on_o}, 4'b1100);
    chk("start_cnt", {round_o, score_o, errors_o}, 24'd0);
  endtask

  // mask[5:0]: strobe on cycle k of SHOW+PAUSE; mask[6]: strobe on the JUDGE
  // cycle; mask[7]: strobe throughout FETCH (wait cycles and handshake cycle).
  task automatic play_round(input logic [7:0] sym, input logic [7:0] mask, input int wait_cyc);
    bit ans, match, corr, last;
    for (int i = 0; i < wait_cyc; i++) begin
      symbol_valid_i = 1'b0;
      symbol_i       = SW'($urandom);
      answer_stb_i   = mask[7];
      step;
      chk("fetch_hold", {symbol_ready_o, symbol_on_o}, 2'b10);
    end
    symbol_valid_i = 1'b1;
    symbol_i       = sym;
    answer_stb_i   = mask[7];
    step;
    symbol_valid_i = 1'b0;
    for (int k = 0; k < ST + PT; k++) begin
      chk("show_on", {symbol_on_o, in_game_o, symbol_ready_o, round_done_stb_o},
          {(k < ST), 1'b1, 1'b0, 1'b0});
      chk("show_sym", current_symbol_o, (k < ST) ? sym : 8'd0);
      answer_stb_i = mask[k];
      start_i      = (k == 1);   // ignored mid-game
      step;
    end
    start_i = 1'b0;
    ans   = |mask[5:0];
    match = (m_round >= m_n) && (m_syms[m_round - m_n] == sym);
    corr  = (ans == match);
    chk("judge_stb", round_done_stb_o, 1'b1);
    chk("judge_correct", round_correct_o, corr);
    answer_stb_i = mask[6];
    step;
    answer_stb_i = 1'b0;
    if (corr) m_score = (m_score == 255) ? 255 : m_score + 1;
    else      m_err++;
    m_syms.push_back(sym);
    last = (m_round == RND - 1);
    m_round++;
    if (m_err == ME)  begin m_done = 1; m_win = 0; end
    else if (last)    begin m_done = 1; m_win = 1; end
    chk("post_cnt", {round_o, score_o, errors_o}, {8'(m_round), 8'(m_score), 8'(m_err)});
    chk("post_state", {result_valid_o, in_game_o, symbol_ready_o},
        m_done ? 3'b100 : 3'b011);
    if (m_done) chk("post_win", win_nlost_o, m_win);
  endtask

  logic [7:0] sa[6], ma[6];
  int         wa[6];

  initial begin
    s_rst_n_i = 1'b0; start_i = 1'b0; answer_stb_i = 1'b0; symbol_valid_i = 1'b0;
    n_sel_i = '0; symbol_i = '0;
    step; step;
    chk_zero("reset");
    s_rst_n_i = 1'b1;
    step;
    chk_zero("idle");

    // Game A: n=2, answers in rounds 2 and 4 are both real matches
    start_game(2);
    sa = '{5, 7, 5, 9, 5, 1};
    ma = '{0, 0, 8'h01, 0, 8'h01, 0};
    for (int r = 0; r < RND; r++) play_round(sa[r], ma[r], 0);
    chk("A_result", {result_valid_o, win_nlost_o, score_o, errors_o}, {1'b1, 1'b1, 8'd6, 8'd0});
    step; step;
    chk("A_hold", {result_valid_o, win_nlost_o, round_o}, {1'b1, 1'b1, 8'd6});

    // Reset in the middle of SHOW
    start_game(1);
    symbol_valid_i = 1'b1; symbol_i = 8'hAA;
    step;
    symbol_valid_i = 1'b0;
    step;
    s_rst_n_i = 1'b0;
    step;
    s_rst_n_i = 1'b1;
    chk_zero("rst_show");

    // Game B: n_sel=0 clamps to 1, repeated symbol, no answers -> lost after round 2
    start_game(0);
    for (int r = 0; r < RND && !m_done; r++) play_round(8'd3, 8'd0, 0);
    chk("B_result", {result_valid_o, win_nlost_o, round_o, errors_o}, {1'b1, 1'b0, 8'd3, 8'd2});

    // Game C: n_sel=7 clamps to 4, FETCH strobe ignored, triple strobe counted once,
    // and a 10-cycle valid-low stall in FETCH
    start_game(7);
    sa = '{1, 2, 3, 4, 1, 9};
    ma = '{8'h80, 0, 0, 0, 8'h25, 0};
    wa = '{0, 10, 0, 0, 0, 0};
    for (int r = 0; r < RND; r++) play_round(sa[r], ma[r], wa[r]);
    chk("C_result", {result_valid_o, win_nlost_o, score_o, errors_o}, {1'b1, 1'b1, 8'd6, 8'd0});

    // Game D: strobe on the last PAUSE cycle counts, strobe on JUDGE does not
    start_game(1);
    sa = '{4, 4, 6, 8, 8, 2};
    ma = '{0, 8'h20, 8'h40, 8'h40, 8'h40, 0};
    for (int r = 0; r < RND; r++) play_round(sa[r], ma[r], 0);
    chk("D_result", {result_valid_o, win_nlost_o, score_o, errors_o}, {1'b1, 1'b1, 8'd5, 8'd1});

    // Random games against the model
    for (int g = 0; g < 5; g++) begin
      start_game($urandom_range(0, 7));
      for (int r = 0; r < RND && !m_done; r++)
        play_round(8'($urandom_range(0, 2)),
                   ($urandom_range(0, 1) != 0) ? 8'(1 << $urandom_range(0, 7)) : 8'd0,
                   $urandom_range(0, 3));
      chk("rnd_done", result_valid_o, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
